// File: rtl/cordic_inv_rotator.sv
// Iterative inverse-rotation CORDIC.
// Takes a vector together with the direction record from a vectoring pass:
// the 180-degree pre-rotation flag and the per-stage u_k values.
// It undoes the micro-rotations in reverse stage order, undoes the
// pre-rotation, and applies a CSD approximation of 1/K so the original
// vector comes back. One shared datapath runs one stage per clock, and
// both sides use valid/ready handshakes.
module cordic_inv_rotator #(
  parameter int C_IWL   = 5,
  parameter int C_FWL   = 15,
  parameter int N_STAGE = 15
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                i_valid,
  output logic                                i_ready,
  input  logic signed [C_IWL+C_FWL-1:0]       i_X,
  input  logic signed [C_IWL+C_FWL-1:0]       i_Y,
  input  logic                                i_rot180,
  input  logic        [2*N_STAGE-1:0]         i_dir,
  output logic                                o_valid,
  input  logic                                i_out_ready,
  output logic signed [C_IWL+C_FWL-1:0]       o_X,
  output logic signed [C_IWL+C_FWL-1:0]       o_Y
);

  localparam int W  = C_IWL + C_FWL;
  localparam int CW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_STAGE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROT,
    S_SCALE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   x_q, x_d;
  logic signed [W-1:0]   y_q, y_d;
  logic [2*N_STAGE-1:0]  dir_q, dir_d;
  logic                  rot180_q, rot180_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [W-1:0]   ox_q, ox_d;
  logic signed [W-1:0]   oy_q, oy_d;
  logic                  ovalid_q, ovalid_d;

  logic [1:0]            uk;
  logic signed [W-1:0]   xSh;
  logic signed [W-1:0]   ySh;
  logic signed [W-1:0]   xRot;
  logic signed [W-1:0]   yRot;
  logic signed [W-1:0]   xNeg;
  logic signed [W-1:0]   yNeg;

  // CSD gain compensation; the six shifted terms approximate 1/K ~ 0.60725.
  // Every term truncates and the sum wraps at W bits.
  function automatic logic signed [W-1:0] csdGain(input logic signed [W-1:0] v);
    logic signed [W-1:0] posSum;
    logic signed [W-1:0] negSum;
    posSum = (v >>> 1) + (v >>> 3) + (v >>> 14);
    negSum = (v >>> 6) + (v >>> 9) + (v >>> 12);
    return posSum - negSum;
  endfunction

  // Select the direction code for the stage currently held in the counter.
  always_comb begin
    uk = 2'b00;
    for (int s = 0; s < N_STAGE; s++) begin
      if (cnt_q == s[CW-1:0]) begin
        uk = dir_q[2*s +: 2];
      end
    end
  end

  // One inverse micro-rotation. Codes 00 and 10 both mean u_k = 0.
  always_comb begin
    xSh  = x_q >>> cnt_q;
    ySh  = y_q >>> cnt_q;
    xRot = x_q;
    yRot = y_q;
    case (uk)
      2'b01: begin
        xRot = x_q + ySh;
        yRot = y_q - xSh;
      end
      2'b11: begin
        xRot = x_q - ySh;
        yRot = y_q + xSh;
      end
      default: begin
        xRot = x_q;
        yRot = y_q;
      end
    endcase
  end

  // Undo the forward 180-degree pre-rotation. The most negative value wraps to itself.
  always_comb begin
    xNeg = rot180_q ? -x_q : x_q;
    yNeg = rot180_q ? -y_q : y_q;
  end

  // Next-state and datapath-update logic for the control FSM.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    rot180_d = rot180_q;
    cnt_d    = cnt_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    ovalid_d = ovalid_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          x_d      = i_X;
          y_d      = i_Y;
          dir_d    = i_dir;
          rot180_d = i_rot180;
          cnt_d    = CNT_LAST;
          state_d  = S_ROT;
        end
      end
      S_ROT: begin
        x_d = xRot;
        y_d = yRot;
        if (cnt_q == '0) begin
          state_d = S_SCALE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_SCALE: begin
        ox_d     = csdGain(xNeg);
        oy_d     = csdGain(yNeg);
        ovalid_d = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (i_out_ready) begin
          ovalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any vector in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= '0;
      rot180_q <= 1'b0;
      cnt_q    <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      rot180_q <= rot180_d;
      cnt_q    <= cnt_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign i_ready = (state_q == S_IDLE);
  assign o_valid = ovalid_q;
  assign o_X     = ox_q;
  assign o_Y     = oy_q;

endmodule
